d5m_frame_replay: RTL and testbench



---
 rtl/d5m_pkg.sv | 39 +++
 rtl/d5m_frame_replay_if.sv | 23 ++
 rtl/d5m_frame_replay.sv | 130 +++++++++++++
 tb/tb_d5m_frame_replay.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/d5m_pkg.sv
// Shared D5M pixel-stream definitions: pixel/word geometry, replay state
// encoding and default frame geometry used by both capture and replay blocks.
package d5m_pkg;

  localparam int unsigned PIXEL_W      = 12;
  localparam int unsigned PIX_PER_WORD = 3;
  localparam int unsigned WORD_W       = PIXEL_W * PIX_PER_WORD;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_H_BLANK  = 16;
  localparam int unsigned DEF_V_BLANK  = 8;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LINE_BLANK  = 2'd1,
    ST_LINE_ACTIVE = 2'd2,
    ST_FRAME_BLANK = 2'd3
  } replay_state_e;

  // Packed FIFO word: oldest pixel in the low slice.
  typedef struct packed {
    logic [PIXEL_W-1:0] pix2;
    logic [PIXEL_W-1:0] pix1;
    logic [PIXEL_W-1:0] pix0;
  } packed_word_t;

  function automatic logic [PIXEL_W-1:0] word_pixel(input packed_word_t w,
                                                    input logic [1:0]   ph);
    logic [PIXEL_W-1:0] p;
    case (ph)
      2'd0:    p = w.pix0;
      2'd1:    p = w.pix1;
      default: p = w.pix2;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/d5m_frame_replay_if.sv
// FIFO-head input and D5M raster output bundle of the frame replay source.
interface d5m_frame_replay_if;
  import d5m_pkg::*;

  packed_word_t       iWORD;
  logic               iWORD_EMPTY;
  logic               oWORD_RDREQ;
  logic [PIXEL_W-1:0] oDATA;
  logic               oDATA_VAL;
  logic               oLVAL;
  logic               oFVAL;

  modport master (
    input  iWORD, iWORD_EMPTY,
    output oWORD_RDREQ, oDATA, oDATA_VAL, oLVAL, oFVAL
  );

  modport slave (
    output iWORD, iWORD_EMPTY,
    input  oWORD_RDREQ, oDATA, oDATA_VAL, oLVAL, oFVAL
  );

endinterface

// File: rtl/d5m_frame_replay.sv
// Replays packed 3-pixel FIFO words as a D5M raster (FVAL/LVAL/DATA) with
// programmable line and frame blanking; stalls hold LVAL and flag underrun.
module d5m_frame_replay
  import d5m_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_BLANK  = DEF_V_BLANK
) (
  input  logic                      D5M_PIXLCLK,
  input  logic                      RST_N,
  input  logic                      iSTART,
  input  logic                      iCONTINUOUS,
  d5m_frame_replay_if.master        bus,
  output logic                      oBUSY,
  output logic                      oUNDERRUN
);

  localparam int unsigned COL_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W   = $clog2(V_ACTIVE + 1);
  localparam int unsigned BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BLK_W   = $clog2(BLK_MAX + 1);

  replay_state_e    state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [BLK_W-1:0] blk_cnt;
  logic [1:0]       phase;

  logic want_pix;
  logic emit;
  logic line_end;
  logic frame_clr;
  logic start_acc;

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; a pixel is fetched in the cycle before it is displayed.
  always_comb begin
    state_nxt = state;
    line_end  = 1'b0;
    frame_clr = 1'b0;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iSTART) begin
          state_nxt = ST_LINE_BLANK;
          frame_clr = 1'b1;
          start_acc = 1'b1;
        end
      end
      ST_LINE_BLANK: begin
        if (blk_cnt == BLK_W'(H_BLANK - 1)) state_nxt = ST_LINE_ACTIVE;
      end
      ST_LINE_ACTIVE: begin
        if (col == COL_W'(H_ACTIVE)) begin
          line_end  = 1'b1;
          state_nxt = (row == ROW_W'(V_ACTIVE - 1)) ? ST_FRAME_BLANK : ST_LINE_BLANK;
        end
      end
      ST_FRAME_BLANK: begin
        if (blk_cnt == BLK_W'(V_BLANK - 1)) begin
          if (iCONTINUOUS) begin
            state_nxt = ST_LINE_BLANK;
            frame_clr = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    want_pix = (state_nxt == ST_LINE_ACTIVE);
    emit     = want_pix && !bus.iWORD_EMPTY;
  end

  assign bus.oWORD_RDREQ = emit && (phase == 2'd2);

  // Phase survives line boundaries since words straddle lines.
  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      col     <= '0;
      row     <= '0;
      phase   <= '0;
      blk_cnt <= '0;
    end else begin
      if (frame_clr) begin
        col   <= '0;
        row   <= '0;
        phase <= '0;
      end else if (line_end) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else if (emit) begin
        col   <= col + COL_W'(1);
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
      if (state_nxt != state)
        blk_cnt <= '0;
      else if (state == ST_LINE_BLANK || state == ST_FRAME_BLANK)
        blk_cnt <= blk_cnt + BLK_W'(1);
    end
  end

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.oDATA     <= '0;
      bus.oDATA_VAL <= 1'b0;
      bus.oLVAL     <= 1'b0;
      bus.oFVAL     <= 1'b0;
      oBUSY         <= 1'b0;
      oUNDERRUN     <= 1'b0;
    end else begin
      bus.oDATA     <= emit ? word_pixel(bus.iWORD, phase) : '0;
      bus.oDATA_VAL <= emit;
      bus.oLVAL     <= (state_nxt == ST_LINE_ACTIVE);
      bus.oFVAL     <= (state_nxt == ST_LINE_BLANK) || (state_nxt == ST_LINE_ACTIVE);
      oBUSY         <= (state_nxt != ST_IDLE);
      if (start_acc)
        oUNDERRUN <= 1'b0;
      else if (want_pix && bus.iWORD_EMPTY)
        oUNDERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_d5m_frame_replay.sv
// Directed bench for d5m_frame_replay on a 6x2 raster with a queue FIFO model.
module tb_d5m_frame_replay;
  import d5m_pkg::*;

  localparam int unsigned HA = 6;
  localparam int unsigned VA = 2;
  localparam int unsigned HB = 2;
  localparam int unsigned VB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cont;
  logic busy;
  logic underrun;

  d5m_frame_replay_if bus();

  d5m_frame_replay #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .D5M_PIXLCLK (clk),
    .RST_N       (rst_n),
    .iSTART      (start),
    .iCONTINUOUS (cont),
    .bus         (bus),
    .oBUSY       (busy),
    .oUNDERRUN   (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] q[$];
  int                hold_cnt = 0;
  logic              pop_pend = 1'b0;
  int                pops, cyc, fval_rises, fval_hi, fb_cnt, stall_cnt, last_fall, gap;
  logic              s_fval = 1'b0;
  logic              s_busy = 1'b0;
  logic [PIXEL_W-1:0] got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mkword(input int i);
    logic [PIXEL_W-1:0] p0, p1, p2;
    p0 = PIXEL_W'(3 * i + 1);
    p1 = PIXEL_W'(3 * i + 2);
    p2 = PIXEL_W'(3 * i + 3);
    return {p2, p1, p0};
  endfunction

  task automatic drive_fifo();
    bus.iWORD       = (q.size() > 0) ? q[0] : '0;
    bus.iWORD_EMPTY = (q.size() == 0) || (hold_cnt > 0);
    if (hold_cnt > 0) hold_cnt--;
  endtask

  task automatic clear_stats();
    pops = 0; cyc = 0; fval_rises = 0; fval_hi = 0; fb_cnt = 0;
    stall_cnt = 0; last_fall = 0; gap = -1;
    got.delete();
  endtask

  // One clock: apply pending pop after the edge, then sample at the falling edge.
  task automatic step();
    logic [WORD_W-1:0] dummy;
    @(posedge clk); #1;
    if (pop_pend) begin
      if (q.size() > 0) dummy = q.pop_front();
      pops++;
    end
    drive_fifo();
    @(negedge clk);
    cyc++;
    if (bus.oFVAL && !s_fval) begin
      fval_rises++;
      if (fval_rises == 2) gap = cyc - last_fall;
    end
    if (!bus.oFVAL && s_fval) last_fall = cyc;
    s_fval = bus.oFVAL;
    s_busy = busy;
    if (bus.oFVAL) fval_hi++;
    if (busy && !bus.oFVAL) fb_cnt++;
    if (bus.oLVAL && !bus.oDATA_VAL) stall_cnt++;
    if (bus.oDATA_VAL) got.push_back(bus.oDATA);
    if (bus.oWORD_RDREQ && bus.iWORD_EMPTY) chk("rdreq_when_empty", 1, 0);
    pop_pend = bus.oWORD_RDREQ;
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while (s_busy && n < bound) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(s_busy), 0);
  endtask

  task automatic load(input int first, input int n);
    for (int i = first; i < first + n; i++) q.push_back(mkword(i));
    drive_fifo();
  endtask

  task automatic check_pixels(input string tag, input int first, input int n);
    chk({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk({tag, "_pix"}, 64'(got[i]), 64'(first + i));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0;
    bus.iWORD = '0; bus.iWORD_EMPTY = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_fval", 64'(bus.oFVAL), 0);
    chk("rst_lval", 64'(bus.oLVAL), 0);
    chk("rst_dval", 64'(bus.oDATA_VAL), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_underrun", 64'(underrun), 0);
    chk("rst_rdreq", 64'(bus.oWORD_RDREQ), 0);

    // Plain frame: 4 words, pixels 1..12.
    clear_stats();
    load(0, 4);
    start = 1'b1; step(); start = 1'b0;
    chk("t1_fval_at_k", 64'(bus.oFVAL), 1);
    chk("t1_busy_at_k", 64'(busy), 1);
    chk("t1_lval_at_k", 64'(bus.oLVAL), 0);
    step();
    chk("t1_dval_at_k1", 64'(bus.oDATA_VAL), 0);
    step();
    chk("t1_lval_at_kHB", 64'(bus.oLVAL), 1);
    chk("t1_dval_at_kHB", 64'(bus.oDATA_VAL), 1);
    chk("t1_data_at_kHB", 64'(bus.oDATA), 1);
    run_until_idle(100);
    check_pixels("t1", 1, 12);
    chk("t1_pops", 64'(pops), 4);
    chk("t1_fval_high", 64'(fval_hi), 64'(VA * (HB + HA)));
    chk("t1_frame_blank", 64'(fb_cnt), 64'(VB));
    chk("t1_underrun", 64'(underrun), 0);
    chk("t1_fifo_left", 64'(q.size()), 0);

    // Stall for 5 cycles in front of pixel 4.
    clear_stats();
    load(0, 4);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    hold_cnt = 5;
    run_until_idle(100);
    check_pixels("t2", 1, 12);
    chk("t2_stall_cycles", 64'(stall_cnt), 5);
    chk("t2_pops", 64'(pops), 4);
    chk("t2_underrun", 64'(underrun), 1);

    // Continuous: two frames back-to-back from 8 words.
    clear_stats();
    load(0, 8);
    cont = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("t3_underrun_cleared", 64'(underrun), 0);
    for (int n = 0; n < 100 && got.size() < 13; n++) step();
    cont = 1'b0;
    run_until_idle(100);
    check_pixels("t3", 1, 24);
    chk("t3_fval_rises", 64'(fval_rises), 2);
    chk("t3_fval_gap", 64'(gap), 64'(VB));
    chk("t3_pops", 64'(pops), 8);
    chk("t3_underrun", 64'(underrun), 0);

    // iSTART while busy is ignored.
    clear_stats();
    load(0, 4);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (12) step();
    chk("t4_in_frame_blank", 64'(bus.oFVAL), 0);
    start = 1'b1; step(); start = 1'b0;
    run_until_idle(100);
    repeat (5) step();
    chk("t4_fval_rises", 64'(fval_rises), 1);
    chk("t4_busy_after", 64'(busy), 0);
    chk("t4_pixels", 64'(got.size()), 12);

    // Async reset mid line 1, then restart from phase 0.
    clear_stats();
    load(0, 4);
    start = 1'b1; step(); start = 1'b0;
    repeat (11) step();
    chk("t5_pre_rst_pixels", 64'(got.size()), 8);
    chk("t5_pre_rst_lval", 64'(bus.oLVAL), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_fval", 64'(bus.oFVAL), 0);
    chk("t5_rst_lval", 64'(bus.oLVAL), 0);
    chk("t5_rst_dval", 64'(bus.oDATA_VAL), 0);
    chk("t5_rst_data", 64'(bus.oDATA), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_rdreq", 64'(bus.oWORD_RDREQ), 0);
    pop_pend = bus.oWORD_RDREQ;
    step();
    rst_n = 1'b1;
    chk("t5_fifo_left", 64'(q.size()), 2);
    clear_stats();
    load(4, 2);
    start = 1'b1; step(); start = 1'b0;
    run_until_idle(100);
    check_pixels("t5", 7, 12);
    chk("t5_pops", 64'(pops), 4);
    chk("t5_underrun", 64'(underrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
